// File: rtl/cpu_defs.sv
// Shared definitions for the ID-stage operand-select logic: mux select codes,
// shadow-slot layout and the slot match helper.
package cpu_defs;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_EXA  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_MEMA = 3'd2;
    localparam logic [SEL_W-1:0] SEL_MEML = 3'd3;
    localparam logic [SEL_W-1:0] SEL_WB   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_IMM  = 3'd5;
    localparam logic [SEL_W-1:0] SEL_LINK = 3'd6;
    localparam logic [SEL_W-1:0] SEL_HILO = 3'd7;

    // One in-flight instruction as seen by the forwarding logic.
    typedef struct packed {
        logic             v;
        logic             wreg;
        logic [REG_W-1:0] rd;
        logic             m2reg;
    } slot_t;

    // A slot can forward to src when it carries a live GPR write to that
    // register; $0 never matches.
    function automatic logic slot_match(slot_t s, logic [REG_W-1:0] src);
        return s.v & s.wreg & (s.rd == src) & (src != '0);
    endfunction

endpackage

// File: rtl/operand_sel_ctrl_if.sv
// ID-stage bundle between decode and the operand-select scheduler.
interface operand_sel_ctrl_if;
    import cpu_defs::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_use_imm;
    logic             id_link;
    logic             id_use_hilo;
    logic             id_md_start;
    logic             id_md_div;
    logic             id_wreg;
    logic [REG_W-1:0] id_rd;
    logic             id_m2reg;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             stall;
    logic             md_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_imm,
               id_link, id_use_hilo, id_md_start, id_md_div, id_wreg,
               id_rd, id_m2reg,
        input  sel_a, sel_b, stall, md_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_imm,
               id_link, id_use_hilo, id_md_start, id_md_div, id_wreg,
               id_rd, id_m2reg,
        output sel_a, sel_b, stall, md_busy
    );

endinterface

// File: rtl/fwd_resolve.sv
// Forwarding resolution for one GPR operand against the EX/MEM/WB shadow slots.
module fwd_resolve
    import cpu_defs::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  slot_t            ex,
    input  slot_t            mem,
    input  slot_t            wb,
    output logic [SEL_W-1:0] sel,
    output logic             load_use
);

    // WB always forwards its final result; its load flag is irrelevant here.
    logic unused_wb_m2reg;
    assign unused_wb_m2reg = wb.m2reg;

    // Youngest matching producer wins; a load still in EX cannot forward yet.
    always_comb begin
        sel      = SEL_RF;
        load_use = 1'b0;
        if (use_src) begin
            if (slot_match(ex, src)) begin
                if (ex.m2reg) begin
                    load_use = 1'b1;
                end else begin
                    sel = SEL_EXA;
                end
            end else if (slot_match(mem, src)) begin
                sel = mem.m2reg ? SEL_MEML : SEL_MEMA;
            end else if (slot_match(wb, src)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/operand_sel_ctrl.sv
// ID-stage operand-select scheduler: tracks in-flight destinations and the
// HI/LO busy window, drives the ALU operand mux selects and the stall.
module operand_sel_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 32,
    parameter int unsigned CNT_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    operand_sel_ctrl_if.slave  bus
);

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] fwd_sel_a, fwd_sel_b;
    logic             fwd_lu_a, fwd_lu_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             load_use;
    logic             md_busy;
    logic             stall;
    logic             md_accept;

    fwd_resolve u_fwd_a (
        .src      (bus.id_rs),
        .use_src  (bus.id_use_rs),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .sel      (fwd_sel_a),
        .load_use (fwd_lu_a)
    );

    fwd_resolve u_fwd_b (
        .src      (bus.id_rt),
        .use_src  (bus.id_use_rt),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .sel      (fwd_sel_b),
        .load_use (fwd_lu_b)
    );

    // Operand selects with overrides; an overridden operand is not read from
    // the GPR path, so its load-use flag is ignored.
    always_comb begin
        sel_a    = SEL_RF;
        sel_b    = SEL_RF;
        load_use = 1'b0;
        if (bus.id_valid) begin
            if (bus.id_link) begin
                sel_a = SEL_LINK;
            end else if (bus.id_use_hilo) begin
                sel_a = SEL_HILO;
            end else begin
                sel_a    = fwd_sel_a;
                load_use = fwd_lu_a;
            end
            if (bus.id_use_imm) begin
                sel_b = SEL_IMM;
            end else begin
                sel_b    = fwd_sel_b;
                load_use = load_use | fwd_lu_b;
            end
        end
    end

    // Stall merge: load-use plus HI/LO read or new mult/div while busy.
    always_comb begin
        md_busy   = (cnt_q != '0);
        stall     = bus.id_valid & (load_use
                                    | (bus.id_use_hilo & md_busy)
                                    | (bus.id_md_start & md_busy));
        md_accept = bus.id_valid & bus.id_md_start & ~stall;
    end

    assign bus.sel_a   = sel_a;
    assign bus.sel_b   = sel_b;
    assign bus.stall   = stall;
    assign bus.md_busy = md_busy;

    // Next shadow-pipeline and busy-counter state.
    always_comb begin
        wb_d        = mem_q;
        mem_d       = ex_q;
        ex_d.v      = bus.id_valid & ~stall;
        ex_d.wreg   = bus.id_wreg;
        ex_d.rd     = bus.id_rd;
        ex_d.m2reg  = bus.id_m2reg;
        cnt_d       = cnt_q;
        if (md_accept) begin
            cnt_d = bus.id_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_operand_sel_ctrl.sv
// Scoreboard bench for operand_sel_ctrl: directed ID vectors push the expected
// selects/stall/busy, a negedge monitor pops and compares.
module tb_operand_sel_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_sel_ctrl_if bus ();

    operand_sel_ctrl #(
        .MULT_LAT (4),
        .DIV_LAT  (32),
        .CNT_W    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [2:0] a;
        logic [2:0] b;
        logic       st;
        logic       bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic imm,
                         input logic link, input logic hilo, input logic mds,
                         input logic mdd, input logic wreg, input logic [4:0] rd,
                         input logic m2r);
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_use_rs   = urs;
        bus.id_use_rt   = urt;
        bus.id_use_imm  = imm;
        bus.id_link     = link;
        bus.id_use_hilo = hilo;
        bus.id_md_start = mds;
        bus.id_md_div   = mdd;
        bus.id_wreg     = wreg;
        bus.id_rd       = rd;
        bus.id_m2reg    = m2r;
    endtask

    task automatic push(input string name, input logic [2:0] a, input logic [2:0] b,
                        input logic st, input logic bz);
        exp_t e;
        e.name = name;
        e.a    = a;
        e.b    = b;
        e.st   = st;
        e.bz   = bz;
        exp_q.push_back(e);
    endtask

    // One valid instruction in ID for one cycle.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic imm, input logic link,
                         input logic hilo, input logic mds, input logic mdd,
                         input logic wreg, input logic [4:0] rd, input logic m2r,
                         input logic [2:0] ea, input logic [2:0] eb, input logic est,
                         input logic ebz, input string name);
        @(posedge clk);
        #1;
        drive(1'b1, rs, rt, urs, urt, imm, link, hilo, mds, mdd, wreg, rd, m2r);
        push(name, ea, eb, est, ebz);
    endtask

    task automatic bubble(input logic ebz, input string name);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        push(name, 3'd0, 3'd0, 1'b0, ebz);
    endtask

    task automatic cmp(input string name, input string field, input logic [2:0] got,
                       input logic [2:0] want);
        n_total++;
        if (got !== want)
            $display("FAIL %s.%s: got %0d, want %0d", name, field, got, want);
        else
            n_pass++;
    endtask

    // Monitor: outputs are presented every cycle; check them mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "sel_a",   bus.sel_a,           e.a);
                cmp(e.name, "sel_b",   bus.sel_b,           e.b);
                cmp(e.name, "stall",   {2'b00, bus.stall},  {2'b00, e.st});
                cmp(e.name, "md_busy", {2'b00, bus.md_busy}, {2'b00, e.bz});
            end
        end
    end

    initial begin
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        bubble(1'b0, "reset0");
        bubble(1'b0, "reset1");
        rst = 1'b0;

        // Back-to-back ALU forwarding of $3 through EX, MEM, WB.
        issue(5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 0, 1, 5'd3,  0, 3'd0, 3'd0, 0, 0, "addu3");
        issue(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1, 5'd10, 0, 3'd1, 3'd0, 0, 0, "fwd_ex");
        issue(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd2, 3'd0, 0, 0, "fwd_mem");
        issue(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd4, 3'd0, 0, 0, "fwd_wb");
        issue(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd0, 0, 0, "fwd_none");

        // $0 never forwards; EX beats MEM.
        issue(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0,  0, 3'd0, 3'd0, 0, 0, "wr_r0");
        issue(5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd0, 0, 0, "rd_r0");
        issue(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4,  0, 3'd0, 3'd0, 0, 0, "wr_r4a");
        issue(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4,  0, 3'd0, 3'd0, 0, 0, "wr_r4b");
        issue(5'd4, 5'd4, 1, 1, 0, 0, 0, 0, 0, 1, 5'd4,  0, 3'd1, 3'd1, 0, 0, "prio_ex");

        // Link and immediate overrides over an EX match.
        issue(5'd4, 5'd4, 1, 1, 1, 1, 0, 0, 0, 1, 5'd31, 0, 3'd6, 3'd5, 0, 0, "ovr_link_imm");

        // Load-use: one stall, bubble into EX, then MEM load data.
        issue(5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 0, 1, 5'd5,  1, 3'd0, 3'd5, 0, 0, "lw5");
        issue(5'd0, 5'd5, 0, 1, 0, 0, 0, 0, 0, 1, 5'd5,  1, 3'd0, 3'd0, 1, 0, "lu_stall");
        issue(5'd0, 5'd5, 0, 1, 0, 0, 0, 0, 0, 1, 5'd5,  1, 3'd0, 3'd3, 0, 0, "lu_meml");
        issue(5'd0, 5'd5, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd0, 1, 0, "lu_again");
        bubble(1'b0, "idle_bubble");
        issue(5'd0, 5'd5, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd4, 0, 0, "lw_wb");

        // Divide then mfhi: 32 busy/stall cycles, then proceeds.
        issue(5'd1, 5'd2, 1, 1, 0, 0, 0, 1, 1, 0, 5'd0,  0, 3'd0, 3'd0, 0, 0, "div");
        for (int unsigned i = 0; i < 32; i++)
            issue(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd8, 0, 3'd7, 3'd0, 1, 1, "mfhi_wait");
        issue(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd8,  0, 3'd7, 3'd0, 0, 0, "mfhi_go");

        // Mult, then a div arriving on the last busy cycle.
        issue(5'd1, 5'd2, 1, 1, 0, 0, 0, 1, 0, 0, 5'd0,  0, 3'd0, 3'd0, 0, 0, "mult");
        bubble(1'b1, "mult_busy4");
        bubble(1'b1, "mult_busy3");
        bubble(1'b1, "mult_busy2");
        issue(5'd1, 5'd2, 1, 1, 0, 0, 0, 1, 1, 0, 5'd0,  0, 3'd0, 3'd0, 1, 1, "div_cnt1");
        issue(5'd1, 5'd2, 1, 1, 0, 0, 0, 1, 1, 0, 5'd0,  0, 3'd0, 3'd0, 0, 0, "div_accept");

        // Reset while the counter is at 20 and a load sits in EX.
        for (int unsigned i = 0; i < 11; i++)
            bubble(1'b1, "div_busy");
        issue(5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 0, 1, 5'd6,  1, 3'd0, 3'd5, 0, 1, "lw6");
        bubble(1'b1, "cnt20");
        rst = 1'b1;
        issue(5'd6, 5'd6, 1, 1, 0, 0, 0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd0, 0, 0, "post_rst_dep");
        rst = 1'b0;
        issue(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd8,  0, 3'd7, 3'd0, 0, 0, "post_rst_mfhi");
        bubble(1'b0, "tail");

        for (int unsigned i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
